// File: rtl/rv_pkg.sv
// Shared definitions for the rv_mc_core multi-cycle RV32I core.
// Holds opcode and funct constants, the ALU operation encoding, the FSM
// state encoding and the funct3-to-ALU-op decode helper.
// Contains no ports.
package rv_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // ALU funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch / memory / jump funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    // funct7
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_TRAP  = 3'd4
    } state_e;

    // Map funct3 plus the alternate bit (funct7[5]) to an ALU operation.
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_mc_alu.sv
// Combinational ALU for rv_mc_core.
// Ports:
//   a, b    : 32-bit operands
//   op      : ALU operation (rv_pkg::alu_op_e encoding)
//   result  : operation result, modulo 2^32
//   eq      : a == b
//   lt      : a < b signed
//   ltu     : a < b unsigned
module rv_mc_alu
    import rv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    // Comparison flags and the selected arithmetic/logic result
    always_comb begin
        eq  = (a == b);
        lt  = ($signed(a) < $signed(b));
        ltu = (a < b);
        case (alu_op_e'(op))
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << b[4:0];
            ALU_SLT:    result = {31'd0, lt};
            ALU_SLTU:   result = {31'd0, ltu};
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> b[4:0];
            ALU_SRA:    result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_PASS_B: result = b;
            default:    result = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv_mc_core.sv
// Multi-cycle RV32I/RV32E core: FETCH -> EXEC -> (MEM) -> WB, with
// req/ack handshakes on separate instruction and data ports so memories
// may insert wait states. Illegal instructions and misaligned targets or
// data addresses park the core in TRAP until reset.
// Optional feature macro: RV_MC_TRACE_EN adds a retirement trace port.
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   imem_req/addr     : fetch request, address = pc
//   imem_ack/rdata    : fetch complete, instruction word
//   dmem_req/we       : data request, 1 = store
//   dmem_addr/wdata   : byte address, store data
//   dmem_ack/rdata    : data complete, load data
//   halted            : core stopped in TRAP
//   retire_* (trace)  : one-cycle retirement pulse with pc, insn, rd data
module rv_mc_core
    import rv_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            halted
`ifdef RV_MC_TRACE_EN
    ,
    output logic            retire_valid,
    output logic [XLEN-1:0] retire_pc,
    output logic [31:0]     retire_insn,
    output logic [XLEN-1:0] retire_rd_wdata
`endif
);

    localparam int RW = $clog2(NREGS);

    if (XLEN != 32) begin : g_bad_xlen
        $fatal(1, "rv_mc_core: XLEN must be 32");
    end
    if ((NREGS != 32) && (NREGS != 16)) begin : g_bad_nregs
        $fatal(1, "rv_mc_core: NREGS must be 16 or 32");
    end

    state_e      state_r;
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic [31:0] regs_r [NREGS];
    logic [31:0] wb_data_r;
    logic [31:0] npc_r;
    logic        wr_en_r;
    logic        imem_req_r;
    logic        dmem_req_r;
    logic        dmem_we_r;
    logic [31:0] dmem_addr_r;
    logic [31:0] dmem_wdata_r;
    logic        halted_r;

    // Instruction fields and immediates
    logic [6:0]  opcode_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [31:0] rs1_val_s, rs2_val_s;
    logic [31:0] pc_plus4_s;

    assign opcode_s   = ir_r[6:0];
    assign rd_s       = ir_r[11:7];
    assign f3_s       = ir_r[14:12];
    assign rs1_s      = ir_r[19:15];
    assign rs2_s      = ir_r[24:20];
    assign f7_s       = ir_r[31:25];
    assign imm_i_s    = {{20{ir_r[31]}}, ir_r[31:20]};
    assign imm_s_s    = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
    assign imm_b_s    = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
    assign imm_u_s    = {ir_r[31:12], 12'd0};
    assign imm_j_s    = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
    assign pc_plus4_s = pc_r + 32'd4;

    // x0 is hard-wired to zero regardless of storage contents
    assign rs1_val_s = (rs1_s[RW-1:0] == RW'(0)) ? 32'd0 : regs_r[rs1_s[RW-1:0]];
    assign rs2_val_s = (rs2_s[RW-1:0] == RW'(0)) ? 32'd0 : regs_r[rs2_s[RW-1:0]];

    // ALU
    logic [31:0] alu_a_s, alu_b_s, alu_res_s;
    alu_op_e     alu_op_s;
    logic        alu_eq_s, alu_lt_s, unused_ltu_s;

    rv_mc_alu u_alu (
        .a      (alu_a_s),
        .b      (alu_b_s),
        .op     (alu_op_s),
        .result (alu_res_s),
        .eq     (alu_eq_s),
        .lt     (alu_lt_s),
        .ltu    (unused_ltu_s)
    );

    // Decode results consumed by the EXEC state
    logic        legal_s, is_mem_s, is_store_s, wr_en_s, misalign_s;
    logic        uses_rs1_s, uses_rs2_s, reg_bad_s, trap_s;
    logic [31:0] wb_val_s, npc_s;

    // Decode ir: operand selection, legality, next pc and writeback value
    always_comb begin
        alu_a_s    = rs1_val_s;
        alu_b_s    = rs2_val_s;
        alu_op_s   = ALU_ADD;
        legal_s    = 1'b0;
        is_mem_s   = 1'b0;
        is_store_s = 1'b0;
        wr_en_s    = 1'b0;
        misalign_s = 1'b0;
        uses_rs1_s = 1'b0;
        uses_rs2_s = 1'b0;
        npc_s      = pc_plus4_s;
        wb_val_s   = alu_res_s;
        case (opcode_s)
            OPC_OP: begin
                uses_rs1_s = 1'b1;
                uses_rs2_s = 1'b1;
                wr_en_s    = 1'b1;
                alu_op_s   = f3_to_alu(f3_s, f7_s[5]);
                legal_s    = (f7_s == F7_BASE) ||
                             ((f7_s == F7_ALT) && ((f3_s == F3_ADD_SUB) || (f3_s == F3_SRL_SRA)));
            end
            OPC_OP_IMM: begin
                uses_rs1_s = 1'b1;
                wr_en_s    = 1'b1;
                alu_b_s    = imm_i_s;
                alu_op_s   = f3_to_alu(f3_s, (f3_s == F3_SRL_SRA) && f7_s[5]);
                if (f3_s == F3_SLL) begin
                    legal_s = (f7_s == F7_BASE);
                end else if (f3_s == F3_SRL_SRA) begin
                    legal_s = (f7_s == F7_BASE) || (f7_s == F7_ALT);
                end else begin
                    legal_s = 1'b1;
                end
            end
            OPC_LUI: begin
                wr_en_s  = 1'b1;
                legal_s  = 1'b1;
                alu_b_s  = imm_u_s;
                alu_op_s = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                wr_en_s  = 1'b1;
                legal_s  = 1'b1;
                alu_a_s  = pc_r;
                alu_b_s  = imm_u_s;
            end
            OPC_LOAD: begin
                uses_rs1_s = 1'b1;
                wr_en_s    = 1'b1;
                is_mem_s   = 1'b1;
                alu_b_s    = imm_i_s;
                legal_s    = (f3_s == F3_LW);
                misalign_s = (alu_res_s[1:0] != 2'b00);
            end
            OPC_STORE: begin
                uses_rs1_s = 1'b1;
                uses_rs2_s = 1'b1;
                is_mem_s   = 1'b1;
                is_store_s = 1'b1;
                alu_b_s    = imm_s_s;
                legal_s    = (f3_s == F3_SW);
                misalign_s = (alu_res_s[1:0] != 2'b00);
            end
            OPC_BRANCH: begin
                uses_rs1_s = 1'b1;
                uses_rs2_s = 1'b1;
                alu_op_s   = ALU_SUB;
                legal_s    = 1'b1;
                case (f3_s)
                    F3_BEQ:  npc_s = alu_eq_s  ? (pc_r + imm_b_s) : pc_plus4_s;
                    F3_BNE:  npc_s = !alu_eq_s ? (pc_r + imm_b_s) : pc_plus4_s;
                    F3_BLT:  npc_s = alu_lt_s  ? (pc_r + imm_b_s) : pc_plus4_s;
                    F3_BGE:  npc_s = !alu_lt_s ? (pc_r + imm_b_s) : pc_plus4_s;
                    default: legal_s = 1'b0;
                endcase
                misalign_s = (npc_s[1:0] != 2'b00);
            end
            OPC_JAL: begin
                wr_en_s    = 1'b1;
                legal_s    = 1'b1;
                wb_val_s   = pc_plus4_s;
                npc_s      = pc_r + imm_j_s;
                misalign_s = (npc_s[1:0] != 2'b00);
            end
            OPC_JALR: begin
                uses_rs1_s = 1'b1;
                wr_en_s    = 1'b1;
                alu_b_s    = imm_i_s;
                legal_s    = (f3_s == F3_JALR);
                wb_val_s   = pc_plus4_s;
                npc_s      = alu_res_s & 32'hFFFF_FFFE;
                misalign_s = (npc_s[1:0] != 2'b00);
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    // RV32E: register specifiers above x15 are illegal for fields actually used
    assign reg_bad_s = (NREGS == 16) &&
                       ((uses_rs1_s && rs1_s[4]) || (uses_rs2_s && rs2_s[4]) || (wr_en_s && rd_s[4]));
    assign trap_s    = !legal_s || misalign_s || reg_bad_s;

    // Main FSM, register file and registered memory-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_FETCH;
            pc_r         <= RESET_PC;
            ir_r         <= 32'd0;
            wb_data_r    <= 32'd0;
            npc_r        <= 32'd0;
            wr_en_r      <= 1'b0;
            imem_req_r   <= 1'b0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 32'd0;
            dmem_wdata_r <= 32'd0;
            halted_r     <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    // Request is raised on the first FETCH cycle after reset;
                    // otherwise it was already raised on entry.
                    if (imem_req_r && imem_ack) begin
                        ir_r       <= imem_rdata;
                        imem_req_r <= 1'b0;
                        state_r    <= ST_EXEC;
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    npc_r   <= npc_s;
                    wr_en_r <= wr_en_s;
                    if (trap_s) begin
                        halted_r <= 1'b1;
                        state_r  <= ST_TRAP;
                    end else if (is_mem_s) begin
                        dmem_req_r   <= 1'b1;
                        dmem_we_r    <= is_store_s;
                        dmem_addr_r  <= alu_res_s;
                        dmem_wdata_r <= is_store_s ? rs2_val_s : 32'd0;
                        state_r      <= ST_MEM;
                    end else begin
                        wb_data_r <= wb_val_s;
                        state_r   <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                        if (dmem_we_r) begin
                            pc_r       <= npc_r;
                            imem_req_r <= 1'b1;
                            state_r    <= ST_FETCH;
                        end else begin
                            wb_data_r <= dmem_rdata;
                            state_r   <= ST_WB;
                        end
                    end else begin
                        dmem_req_r <= 1'b1;
                    end
                end
                ST_WB: begin
                    if (wr_en_r && (rd_s != 5'd0)) begin
                        regs_r[rd_s[RW-1:0]] <= wb_data_r;
                    end else begin
                        wr_en_r <= 1'b0;
                    end
                    pc_r       <= npc_r;
                    imem_req_r <= 1'b1;
                    state_r    <= ST_FETCH;
                end
                ST_TRAP: begin
                    halted_r   <= 1'b1;
                    imem_req_r <= 1'b0;
                    dmem_req_r <= 1'b0;
                end
                default: begin
                    halted_r   <= 1'b1;
                    imem_req_r <= 1'b0;
                    dmem_req_r <= 1'b0;
                    state_r    <= ST_TRAP;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_wdata = dmem_wdata_r;
    assign halted     = halted_r;

`ifdef RV_MC_TRACE_EN
    logic        retire_valid_r;
    logic [31:0] retire_pc_r;
    logic [31:0] retire_insn_r;
    logic [31:0] retire_rd_wdata_r;

    // Retirement trace: WB exit, or MEM exit of a store
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_valid_r    <= 1'b0;
            retire_pc_r       <= 32'd0;
            retire_insn_r     <= 32'd0;
            retire_rd_wdata_r <= 32'd0;
        end else if ((state_r == ST_WB) || ((state_r == ST_MEM) && dmem_ack && dmem_we_r)) begin
            retire_valid_r    <= 1'b1;
            retire_pc_r       <= pc_r;
            retire_insn_r     <= ir_r;
            retire_rd_wdata_r <= ((state_r == ST_WB) && wr_en_r && (rd_s != 5'd0)) ? wb_data_r : 32'd0;
        end else begin
            retire_valid_r    <= 1'b0;
        end
    end

    assign retire_valid    = retire_valid_r;
    assign retire_pc       = retire_pc_r;
    assign retire_insn     = retire_insn_r;
    assign retire_rd_wdata = retire_rd_wdata_r;
`endif

endmodule
